// File: rtl/layer_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : layer_mem_arbiter
// Purpose : Round-robin arbiter sharing the layer-memory port between the
//           conv/ReLU writer (0) and the max-pool engine (1), with burst lock.
//           Define ARB_STATS_EN to add grant and conflict counters.
// Revision: 1.0
// ============================================================================
module layer_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 20,
    parameter int SW       = 3,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [SW-1:0] sel0,
    input  logic [SW-1:0] sel1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          cwr,
    output logic          crd,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    output logic [SW-1:0] csel,
`ifdef ARB_STATS_EN
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1,
    output logic [15:0]   conflict_cnt,
`endif
    input  logic [DW-1:0] cdata_rd
);

    localparam int c_CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_OWN0     = 2'd1,
        ST_OWN1     = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last;
    logic [c_CNT_W-1:0]   r_lock_cnt;

    logic                 r_cwr;
    logic                 r_crd;
    logic [AW-1:0]        r_caddr_wr;
    logic [AW-1:0]        r_caddr_rd;
    logic [DW-1:0]        r_cdata_wr;
    logic [SW-1:0]        r_csel;
    logic                 r_rd_idx;
    logic                 r_rvalid0;
    logic                 r_rvalid1;
    logic [DW-1:0]        r_rdata;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_gnt_any;
    logic                 w_idx;
    logic                 w_we;
    logic                 w_lock;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_wdata;
    logic [SW-1:0]        w_sel;

    // An owner excludes the other requester; otherwise a tie goes opposite to r_last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ST_OWN0: w_gnt0 = req0;
            ST_OWN1: w_gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    w_gnt0 = r_last;
                    w_gnt1 = ~r_last;
                end else begin
                    w_gnt0 = req0;
                    w_gnt1 = req1;
                end
            end
        endcase
    end

    assign w_gnt_any = w_gnt0 | w_gnt1;
    assign w_idx     = w_gnt1;
    assign w_we      = w_idx ? we1    : we0;
    assign w_lock    = w_idx ? lock1  : lock0;
    assign w_addr    = w_idx ? addr1  : addr0;
    assign w_wdata   = w_idx ? wdata1 : wdata0;
    assign w_sel     = w_idx ? sel1   : sel0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_UNLOCKED;
            r_last     <= 1'b1;
            r_lock_cnt <= '0;
            r_cwr      <= 1'b0;
            r_crd      <= 1'b0;
            r_caddr_wr <= '0;
            r_caddr_rd <= '0;
            r_cdata_wr <= '0;
            r_csel     <= '0;
            r_rd_idx   <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_cwr <= w_gnt_any && w_we;
            r_crd <= w_gnt_any && !w_we;
            if (w_gnt_any) begin
                r_csel <= w_sel;
                if (w_we) begin
                    r_caddr_wr <= w_addr;
                    r_cdata_wr <= w_wdata;
                end else begin
                    r_caddr_rd <= w_addr;
                    r_rd_idx   <= w_idx;
                end
            end

            // Memory answers combinationally during the strobe cycle.
            r_rvalid0 <= r_crd && !r_rd_idx;
            r_rvalid1 <= r_crd && r_rd_idx;
            if (r_crd) begin
                r_rdata <= cdata_rd;
            end

            if (w_gnt_any) begin
                r_last <= w_idx;
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_lock && (MAX_LOCK > 1)) begin
                            r_state    <= w_idx ? ST_OWN1 : ST_OWN0;
                            r_lock_cnt <= c_CNT_W'(1);
                        end
                    end
                    default: begin
                        // Forced release once the burst reaches MAX_LOCK grants.
                        if (!w_lock || (r_lock_cnt >= c_LOCK_LAST)) begin
                            r_state    <= ST_UNLOCKED;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign cwr      = r_cwr;
    assign crd      = r_crd;
    assign caddr_wr = r_caddr_wr;
    assign caddr_rd = r_caddr_rd;
    assign cdata_wr = r_cdata_wr;
    assign csel     = r_csel;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = r_rdata;

`ifdef ARB_STATS_EN
    logic [15:0] r_gcnt0;
    logic [15:0] r_gcnt1;
    logic [15:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = req0 && req1 && (w_gnt0 != w_gnt1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gcnt0        <= '0;
            r_gcnt1        <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt0 && (r_gcnt0 != 16'hFFFF)) begin
                r_gcnt0 <= r_gcnt0 + 16'd1;
            end
            if (w_gnt1 && (r_gcnt1 != 16'hFFFF)) begin
                r_gcnt1 <= r_gcnt1 + 16'd1;
            end
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign gcnt0        = r_gcnt0;
    assign gcnt1        = r_gcnt1;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/layer_mem_arbiter.md
Name: layer_mem_arbiter

Overview:
- Shares the single layer-memory port (csel/cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd) between two requesters: requester 0 is the conv/ReLU writer; requester 1 is the max-pool read/write engine.
- Round-robin arbitration, one transaction per cycle.
- Optional lock, so a requester can run an uninterrupted burst (e.g. 4 pool reads plus 1 write).
- Sits between the compute engines and the testbench-facing memory pins.

Parameters:
- AW, 12, memory address width
- DW, 20, data width
- SW, 3, csel width
- MAX_LOCK, 8, maximum consecutive grants under one lock before forced release

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  request valid; held with its attributes until the matching gnt
- we0, we1  in  1  1 = write, 0 = read
- lock0, lock1  in  1  keep ownership after this transaction
- addr0, addr1  in  AW  transaction address
- wdata0, wdata1  in  DW  write data
- sel0, sel1  in  SW  target memory select
- gnt0, gnt1  out  1  combinational; transaction accepted this cycle
- rvalid0, rvalid1  out  1  registered; read data valid, 1-cycle pulse
- rdata  out  DW  registered read data, shared by both requesters
- cwr, crd  out  1  registered memory write/read strobes
- caddr_wr, caddr_rd  out  AW  registered memory addresses
- cdata_wr  out  DW  registered write data
- csel  out  SW  registered memory select
- cdata_rd  in  DW  memory read data; combinational from caddr_rd/csel while crd=1

Behaviour:
- Reset values: all outputs 0. RR pointer last=1, so requester 0 wins the first contest. State UNLOCKED, lock_cnt=0.
- Reset mid-operation aborts everything: the pending rvalid is dropped and ownership is cleared.
- States:
  - UNLOCKED: arbitration is open.
  - OWN0 / OWN1: only that requester can be granted.
- Grant rules, UNLOCKED:
  - Only one request: grant it.
  - Both request: grant the one opposite to last.
  - last updates to the granted index on every grant.
- Grant rules, OWNx:
  - gnt_x = req_x; the other requester is never granted.
  - If the owner is idle, no transaction issues and cwr=crd=0.
- Transitions:
  - UNLOCKED -> OWNx on a grant with lock_x=1; lock_cnt=1.
  - OWNx -> UNLOCKED on a grant with lock_x=0.
  - OWNx -> UNLOCKED when a grant makes lock_cnt reach MAX_LOCK. That transaction still issues normally; lock_x is ignored. last=x, so the other requester wins the next contest.
  - Otherwise lock_cnt increments per owner grant.
- Pipeline, gnt in cycle T:
  - T+1 write: cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel.
  - T+1 read: crd=1, caddr_rd=addr, csel=sel.
  - Read: cdata_rd is sampled at the T+1/T+2 edge; rdata is valid and rvalid_x=1 during T+2.
- Throughput:
  - Back-to-back grants allowed every cycle, mixing reads and writes.
  - Exactly one of cwr/crd per issuing cycle; never both.
- Idle cycles:
  - cwr=crd=0.
  - caddr_wr, caddr_rd, cdata_wr, csel hold their last values.
  - rdata holds its value after rvalid drops.
- Read-after-write: a write granted at T followed by a read of the same address granted at T+1 returns the new data, because memory order equals grant order.
- A requester must not change addr/we/wdata/sel/lock while req=1 and gnt=0. Behaviour is undefined if it does.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs gcnt0 and gcnt1 (16 bits each, saturating at 16'hFFFF) counting grants, and conflict_cnt (16 bits, saturating) counting cycles where both req were high and one was denied. All reset to 0.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset, then req0 write only (addr0=12'h041, wdata0=20'h01234, sel0=1) -> gnt0 in T; cwr=1, caddr_wr=041, cdata_wr=01234, csel=1 in T+1; all strobes 0 in T+2.
- req0 and req1 both issue reads for 4 cycles (addr 0x000 / 0x800) -> grants alternate 0,1,0,1; crd high 4 consecutive cycles; rvalid alternates 0,1,0,1 from T+2; rdata matches the memory model.
- req1 with lock1=1 for 4 reads, then a write with lock1=0, while req0 is held high -> gnt1 for 5 consecutive cycles; gnt0 stays 0 until the cycle after the unlocking write, then is granted.
- MAX_LOCK=8, req1 with lock1 always 1 and req0 high -> after the 8th gnt1, the next grant goes to req0; req1 is re-granted via round-robin after that.
- Write 20'h0ABCD to 12'h100 at T, then read 12'h100 at T+1 -> rvalid with rdata=0ABCD at T+3.
- Assert reset for 1 cycle between a read grant and its rvalid -> no rvalid; all outputs 0 and state UNLOCKED after reset.
